surf_dna_seq: RTL and testbench

//  Autonomous sequencer for the DNA_PORTE2 device-ID primitive. On start it loads the DNA shift register,

---
 rtl/surf_dna_seq.sv | 176 +++++++++++++++++
 tb/tb_surf_dna_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/surf_dna_seq.sv
// rtl/surf_dna_seq.sv - DNA_PORTE2 read sequencer presenting the device ID as an atomic parallel register
// Optional DNA_SEQ_VERIFY_EN: every read runs two passes and flags any bit disagreement on mismatch_o.
module surf_dna_seq #(
  parameter int DNA_BITS   = 96,
  parameter int SHIFT_DIV  = 0,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [DNA_BITS-1:0] dna_o,
  output logic                mismatch_o,
  output logic                dna_read_o,
  output logic                dna_shift_o,
  input  logic                dna_dat_i
);

  localparam int KW = (DNA_BITS > 1) ? $clog2(DNA_BITS) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(DNA_BITS - 1);
  localparam logic [3:0]    DIV_LAST = 4'(SHIFT_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [3:0]          div_q, div_d;
  logic [DNA_BITS-1:0] shadow_q, shadow_d;
  logic [DNA_BITS-1:0] dna_q, dna_d;
  logic                valid_q, valid_d;
  logic                auto_q;
  logic                capture;
  logic                last_bit;

`ifdef DNA_SEQ_VERIFY_EN
  logic pass_q, pass_d;
  logic mis_acc_q, mis_acc_d;
  logic mis_q, mis_d;
  logic bit_diff;
`endif

  assign capture  = (div_q == DIV_LAST);
  assign last_bit = (k_q == K_LAST);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    div_d       = div_q;
    shadow_d    = shadow_q;
    dna_d       = dna_q;
    valid_d     = valid_q;
    busy_o      = 1'b0;
    dna_read_o  = 1'b0;
    dna_shift_o = 1'b0;
`ifdef DNA_SEQ_VERIFY_EN
    pass_d      = pass_q;
    mis_acc_d   = mis_acc_q;
    mis_d       = mis_q;
    bit_diff    = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // dna_o is left alone here so readers never see a partially captured ID
        if (start_i || auto_q) begin
          state_d = S_LOAD;
          valid_d = 1'b0;
`ifdef DNA_SEQ_VERIFY_EN
          pass_d    = 1'b0;
          mis_acc_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        busy_o     = 1'b1;
        dna_read_o = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        busy_o  = 1'b1;
        k_d     = '0;
        div_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy_o = 1'b1;
        if (!capture) begin
          div_d = div_q + 4'd1;
        end else begin
          div_d = '0;
`ifdef DNA_SEQ_VERIFY_EN
          if (pass_q) begin
            bit_diff = (dna_dat_i != shadow_q[k_q]);
          end else begin
            shadow_d[k_q] = dna_dat_i;
          end
          mis_acc_d = mis_acc_q | bit_diff;
`else
          shadow_d[k_q] = dna_dat_i;
`endif
          // The primitive already presents the final bit, so it is never shifted past
          if (!last_bit) begin
            dna_shift_o = 1'b1;
            k_d         = k_q + 1'b1;
          end
`ifdef DNA_SEQ_VERIFY_EN
          else if (!pass_q) begin
            pass_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d   = S_DONE;
            valid_d   = 1'b1;
            dna_d     = shadow_q;
            mis_d     = mis_acc_q | bit_diff;
            pass_d    = 1'b0;
            mis_acc_d = 1'b0;
          end
`else
          else begin
            state_d = S_DONE;
            valid_d = 1'b1;
            dna_d   = shadow_d;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      div_q     <= '0;
      shadow_q  <= '0;
      dna_q     <= '0;
      valid_q   <= 1'b0;
      auto_q    <= AUTO_START;
`ifdef DNA_SEQ_VERIFY_EN
      pass_q    <= 1'b0;
      mis_acc_q <= 1'b0;
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      dna_q     <= dna_d;
      valid_q   <= valid_d;
      auto_q    <= 1'b0;
`ifdef DNA_SEQ_VERIFY_EN
      pass_q    <= pass_d;
      mis_acc_q <= mis_acc_d;
      mis_q     <= mis_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign dna_o   = dna_q;
`ifdef DNA_SEQ_VERIFY_EN
  assign mismatch_o = mis_q;
`else
  assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_surf_dna_seq.sv
// tb/tb_surf_dna_seq.sv - self-checking bench for surf_dna_seq with a behavioural DNA_PORTE2 model
// Builds with or without DNA_SEQ_VERIFY_EN; expected latency and mismatch follow the build.
module tb_surf_dna_seq;
  localparam int NB = 96;
  localparam logic [NB-1:0] MAGIC  = 96'hA5A5_0123_4567_89AB_CDEF_0F1E;
  localparam logic [NB-1:0] MAGIC2 = 96'h1234_5678_9ABC_DEF0_0FED_CBA9;
`ifdef DNA_SEQ_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  typedef struct {
    int            inst;
    logic [NB-1:0] val;
    int            extra_at;
    int            flip_bit;
    int            exp_lat;
    logic          exp_mis;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst_n, start, busy, valid, mis, rd, sh, dat;
  logic [NB-1:0] dna [2];
  logic [NB-1:0] id_v [2];
  logic [NB-1:0] flip_mask [2];
  logic [NB-1:0] sr [2] = '{96'd0, 96'd0};
  int            rd_tot [2] = '{0, 0};
  int            rd_base [2];
  logic [NB-1:0] last_dna [2];
  logic          last_mis [2];
  int            checks = 0;
  int            errors = 0;

  surf_dna_seq #(.DNA_BITS(NB), .SHIFT_DIV(0), .AUTO_START(1'b1)) u_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n[0]), .start_i(start[0]), .busy_o(busy[0]),
    .valid_o(valid[0]), .dna_o(dna[0]), .mismatch_o(mis[0]), .dna_read_o(rd[0]),
    .dna_shift_o(sh[0]), .dna_dat_i(dat[0]));

  surf_dna_seq #(.DNA_BITS(NB), .SHIFT_DIV(3), .AUTO_START(1'b0)) u_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n[1]), .start_i(start[1]), .busy_o(busy[1]),
    .valid_o(valid[1]), .dna_o(dna[1]), .mismatch_o(mis[1]), .dna_read_o(rd[1]),
    .dna_shift_o(sh[1]), .dna_dat_i(dat[1]));

  // DNA_PORTE2: READ loads the ID (optionally corrupted on the second read of a sequence), SHIFT moves toward DOUT
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rd[m]) begin
        sr[m]     <= (((rd_tot[m] - rd_base[m]) % 2) == 1) ? (id_v[m] ^ flip_mask[m]) : id_v[m];
        rd_tot[m] <= rd_tot[m] + 1;
      end else if (sh[m]) begin
        sr[m] <= sr[m] >> 1;
      end
    end
  end
  assign dat = {sr[1][0], sr[0][0]};

  function automatic int div_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int ref_latency(input int i);
    return 1 + PASSES * (2 + NB * (div_of(i) + 1));
  endfunction

  function automatic logic ref_mis(input int flip_bit);
    return (PASSES == 2) && (flip_bit >= 0);
  endfunction

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_seq(input int i, input bit auto_go, input logic [NB-1:0] val,
                         input int extra_at, input int flip_bit, input int exp_lat, input logic exp_mis);
    int got, reads, shifts, last_sh;
    bit tear, overlap, gap_bad;
    logic [NB-1:0] one;
    one = 1;
    id_v[i]      = val;
    flip_mask[i] = (flip_bit >= 0) ? (one << flip_bit) : '0;
    rd_base[i]   = rd_tot[i];
    got = -1; reads = 0; shifts = 0; last_sh = -1;
    tear = 1'b0; overlap = 1'b0; gap_bad = 1'b0;
    @(negedge clk);
    if (auto_go) rst_n[i] = 1'b1;
    else start[i] = 1'b1;
    for (int t = 1; t <= exp_lat + 40; t++) begin
      @(negedge clk);
      if (t == 1) begin
        start[i] = 1'b0;
        chk("t1_read", rd[i], 1);
        chk("t1_busy", busy[i], 1);
        chk("t1_valid", valid[i], 0);
      end
      if (t == extra_at) start[i] = 1'b1;
      else if (t == extra_at + 1) start[i] = 1'b0;
      if (rd[i]) reads++;
      if (rd[i] && sh[i]) overlap = 1'b1;
      if (sh[i]) begin
        if ((shifts % (NB - 1)) != 0 && (t - last_sh) != div_of(i) + 1) gap_bad = 1'b1;
        last_sh = t;
        shifts++;
      end
      if (valid[i]) begin
        got = t;
        break;
      end
      if (dna[i] !== last_dna[i] || mis[i] !== last_mis[i]) tear = 1'b1;
    end
    start[i] = 1'b0;
    chk("latency", got, exp_lat);
    chk("dna_value", dna[i], val);
    chk("mismatch", mis[i], exp_mis);
    chk("busy_at_done", busy[i], 0);
    chk("read_pulses", reads, PASSES);
    chk("shift_pulses", shifts, PASSES * (NB - 1));
    chk("no_tearing", tear, 0);
    chk("no_read_shift_overlap", overlap, 0);
    chk("shift_spacing", gap_bad, 0);
    last_dna[i] = val;
    last_mis[i] = exp_mis;
  endtask

  task automatic chk_all_zero(input int i, input string tag);
    chk({tag, "_busy"}, busy[i], 0);
    chk({tag, "_valid"}, valid[i], 0);
    chk({tag, "_dna"}, dna[i], 0);
    chk({tag, "_mismatch"}, mis[i], 0);
    chk({tag, "_read"}, rd[i], 0);
    chk({tag, "_shift"}, sh[i], 0);
  endtask

  task automatic reset_mid(input int i, input int at);
    int sh_cnt, rd_cnt;
    sh_cnt = 0; rd_cnt = 0;
    @(negedge clk);
    start[i] = 1'b1;
    for (int t = 1; t <= at; t++) begin
      @(negedge clk);
      if (t == 1) start[i] = 1'b0;
    end
    chk("pre_reset_busy", busy[i], 1);
    rst_n[i] = 1'b0;
    #1;
    chk_all_zero(i, "mid_reset");
    repeat (5) begin
      @(negedge clk);
      if (sh[i]) sh_cnt++;
      if (rd[i]) rd_cnt++;
    end
    chk("reset_no_shift", sh_cnt, 0);
    chk("reset_no_read", rd_cnt, 0);
    last_dna[i] = '0;
    last_mis[i] = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    int idle_reads, idle_busy;
    rst_n = 2'b00;
    start = 2'b00;
    id_v[0] = MAGIC; id_v[1] = MAGIC;
    flip_mask[0] = '0; flip_mask[1] = '0;
    rd_base[0] = 0; rd_base[1] = 0;
    last_dna[0] = '0; last_dna[1] = '0;
    last_mis[0] = 1'b0; last_mis[1] = 1'b0;

    vecs[0] = '{0, MAGIC,  10, -1, ref_latency(0), ref_mis(-1)};
    vecs[1] = '{0, MAGIC2, -1, -1, ref_latency(0), ref_mis(-1)};
    vecs[2] = '{1, MAGIC,  20, -1, ref_latency(1), ref_mis(-1)};
    vecs[3] = '{0, MAGIC,  -1, 17, ref_latency(0), ref_mis(17)};
    vecs[4] = '{0, MAGIC,  -1, -1, ref_latency(0), ref_mis(-1)};
    vecs[5] = '{1, MAGIC2, 40, 95, ref_latency(1), ref_mis(95)};
    vecs[6] = '{1, MAGIC,  -1, -1, ref_latency(1), ref_mis(-1)};

    repeat (3) @(negedge clk);
    chk_all_zero(0, "reset_a");
    chk_all_zero(1, "reset_b");

    // Without auto-start the second instance must stay idle after reset release
    rst_n[1] = 1'b1;
    idle_reads = 0; idle_busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd[1]) idle_reads++;
      if (busy[1]) idle_busy++;
    end
    chk("no_auto_read", idle_reads, 0);
    chk("no_auto_busy", idle_busy, 0);
    chk("no_auto_valid", valid[1], 0);

    run_seq(0, 1'b1, MAGIC, -1, -1, ref_latency(0), ref_mis(-1));

    for (int v = 0; v < 7; v++)
      run_seq(vecs[v].inst, 1'b0, vecs[v].val, vecs[v].extra_at, vecs[v].flip_bit,
              vecs[v].exp_lat, vecs[v].exp_mis);

    reset_mid(0, 50);
    run_seq(0, 1'b1, MAGIC2, -1, -1, ref_latency(0), ref_mis(-1));

    for (int r = 0; r < 6; r++) begin
      int i, ex, fb;
      logic [NB-1:0] val;
      i   = int'($urandom_range(1, 0));
      val = {$urandom, $urandom, $urandom};
      ex  = int'($urandom_range(79, 2));
      fb  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(NB - 1, 0)) : -1;
      repeat ($urandom_range(4, 0)) @(negedge clk);
      run_seq(i, 1'b0, val, ex, fb, ref_latency(i), ref_mis(fb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
